tile_scheduler: RTL

TILE_SCHEDULER -- requirements
Module: tile_scheduler

---
 rtl/tile_scheduler_if.sv | 20 ++
 rtl/tile_scheduler.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/tile_scheduler_if.sv
// Scheduler-to-DMA tile handshake: tile launch with addresses, completion pulse back.
interface tile_scheduler_if #(
  parameter int AXI_ADDR_W = 32
);
  logic                  tile_start;
  logic                  tile_last;
  logic [AXI_ADDR_W-1:0] ifm_base_addr;
  logic [AXI_ADDR_W-1:0] ofm_base_addr;
  logic                  tile_done;

  modport master (
    output tile_start, tile_last, ifm_base_addr, ofm_base_addr,
    input  tile_done
  );

  modport slave (
    input  tile_start, tile_last, ifm_base_addr, ofm_base_addr,
    output tile_done
  );
endinterface

// File: rtl/tile_scheduler.sv
// Walks a layer's tile grid row-major, launching one DMA tile at a time.
// Optional perf counters (tiles_completed, layer_cycles) under `TILE_SCHED_PERF_EN.
module tile_scheduler #(
  parameter int AXI_ADDR_W = 32,
  parameter int DIM_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DIM_W-1:0]      num_tiles_x,
  input  logic [DIM_W-1:0]      num_tiles_y,
  input  logic [AXI_ADDR_W-1:0] ifm_base,
  input  logic [AXI_ADDR_W-1:0] ofm_base,
  input  logic [AXI_ADDR_W-1:0] ifm_col_stride,
  input  logic [AXI_ADDR_W-1:0] ifm_row_stride,
  input  logic [AXI_ADDR_W-1:0] ofm_col_stride,
  input  logic [AXI_ADDR_W-1:0] ofm_row_stride,
  tile_scheduler_if.master      dma,
  output logic                  busy,
  output logic                  done
`ifdef TILE_SCHED_PERF_EN
  ,
  output logic [2*DIM_W-1:0]    tiles_completed,
  output logic [31:0]           layer_cycles
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    ADVANCE,
    FINISH
  } state_e;

  state_e state_q, state_d;

  logic [DIM_W-1:0]      nx_q, ny_q, tx_q, ty_q;
  logic [AXI_ADDR_W-1:0] ifm_col_q, ifm_row_q, ofm_col_q, ofm_row_q;
  logic [AXI_ADDR_W-1:0] ifm_row_ptr_q, ofm_row_ptr_q;
  logic [AXI_ADDR_W-1:0] ifm_tile_ptr_q, ofm_tile_ptr_q;

  logic start_acc, done_acc, row_end, last_pos;

  assign start_acc = (state_q == IDLE) && start;
  assign done_acc  = (state_q == WAIT_DONE) && dma.tile_done && !abort;
  assign row_end   = (tx_q == nx_q - DIM_W'(1));
  assign last_pos  = row_end && (ty_q == ny_q - DIM_W'(1));

  assign busy              = (state_q != IDLE);
  assign done              = (state_q == FINISH);
  assign dma.tile_start    = (state_q == ISSUE);
  assign dma.tile_last     = last_pos && ((state_q == ISSUE) || (state_q == WAIT_DONE));
  assign dma.ifm_base_addr = ifm_tile_ptr_q;
  assign dma.ofm_base_addr = ofm_tile_ptr_q;

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: default assignment first so no path through the case leaves state_d unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (num_tiles_x == '0 || num_tiles_y == '0) state_d = FINISH;
          else                                        state_d = ISSUE;
        end
      end
      ISSUE:     state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (dma.tile_done) state_d = last_pos ? FINISH : ADVANCE;
      end
      ADVANCE:   state_d = ISSUE;
      FINISH:    state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    // Abort wins over everything, including a coincident tile_done.
    if (abort && state_q != IDLE) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nx_q           <= '0;
      ny_q           <= '0;
      tx_q           <= '0;
      ty_q           <= '0;
      ifm_col_q      <= '0;
      ifm_row_q      <= '0;
      ofm_col_q      <= '0;
      ofm_row_q      <= '0;
      ifm_row_ptr_q  <= '0;
      ofm_row_ptr_q  <= '0;
      ifm_tile_ptr_q <= '0;
      ofm_tile_ptr_q <= '0;
    end else if (start_acc) begin
      nx_q           <= num_tiles_x;
      ny_q           <= num_tiles_y;
      tx_q           <= '0;
      ty_q           <= '0;
      ifm_col_q      <= ifm_col_stride;
      ifm_row_q      <= ifm_row_stride;
      ofm_col_q      <= ofm_col_stride;
      ofm_row_q      <= ofm_row_stride;
      ifm_row_ptr_q  <= ifm_base;
      ofm_row_ptr_q  <= ofm_base;
      ifm_tile_ptr_q <= ifm_base;
      ofm_tile_ptr_q <= ofm_base;
    end else if (state_q == ADVANCE && !abort) begin
      if (row_end) begin
        // New row: tile pointers restart from the advanced row pointers.
        tx_q           <= '0;
        ty_q           <= ty_q + DIM_W'(1);
        ifm_row_ptr_q  <= ifm_row_ptr_q + ifm_row_q;
        ofm_row_ptr_q  <= ofm_row_ptr_q + ofm_row_q;
        ifm_tile_ptr_q <= ifm_row_ptr_q + ifm_row_q;
        ofm_tile_ptr_q <= ofm_row_ptr_q + ofm_row_q;
      end else begin
        tx_q           <= tx_q + DIM_W'(1);
        ifm_tile_ptr_q <= ifm_tile_ptr_q + ifm_col_q;
        ofm_tile_ptr_q <= ofm_tile_ptr_q + ofm_col_q;
      end
    end
  end

`ifdef TILE_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tiles_completed <= '0;
      layer_cycles    <= '0;
    end else if (start_acc) begin
      tiles_completed <= '0;
      layer_cycles    <= '0;
    end else begin
      if (done_acc) tiles_completed <= tiles_completed + (2*DIM_W)'(1);
      if (busy && layer_cycles != '1) layer_cycles <= layer_cycles + 32'd1;
    end
  end
`endif

endmodule
